// File: rtl/motoro3_hall_decoder.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// motoro3_hall_decoder
//
// Receive side of the three-phase commutation path. The three Hall sensor
// levels are synchronised, debounced and decoded into the commutation step
// number 1..6. Rotation direction, the step period, a signed revolution count
// and error/stall status are derived from accepted step changes. All state
// updates happen on the falling edge of clk.
//
// Parameters
//   FILT_LEN     identical synchronised samples needed to accept a code
//   STALL_LIMIT  step-period count at which the rotor is declared stalled
//
// Ports
//   clk          10 MHz system clock (falling-edge active)
//   nRst         asynchronous active-low reset
//   hallA/B/C    asynchronous Hall sensor levels
//   cntClr       synchronous clear of roundCNT
//   step         decoded step, 0 = invalid/unknown, 1..6 = rotor sector
//   dir          1 = forward (ascending steps), 0 = reverse
//   edgePulse    one-cycle strobe on each accepted valid step change
//   stepPeriod   clk cycles between the last two edgePulses
//   periodValid  stepPeriod comes from two adjacent-step edges
//   roundCNT     signed revolution count, two's-complement wrap
//   hallErr      one-cycle pulse when an illegal code is accepted
//   skipErr      one-cycle pulse when a non-adjacent step change is accepted
//   stall        no accepted edge within STALL_LIMIT cycles
// ---------------------------------------------------------------------------
module motoro3_hall_decoder #(
  parameter int unsigned FILT_LEN    = 8,
  parameter logic [24:0] STALL_LIMIT = 25'd1_666_667
) (
  input  logic        clk,
  input  logic        nRst,
  input  logic        hallA,
  input  logic        hallB,
  input  logic        hallC,
  input  logic        cntClr,
  output logic [3:0]  step,
  output logic        dir,
  output logic        edgePulse,
  output logic [24:0] stepPeriod,
  output logic        periodValid,
  output logic [31:0] roundCNT,
  output logic        hallErr,
  output logic        skipErr,
  output logic        stall
);

  localparam logic [7:0] FILT_MAX = 8'(FILT_LEN - 1);

  logic [2:0]  sync1_q, sync2_q, cand_q, acc_q;
  logic [7:0]  filtCnt_q, filtCnt_d;
  logic        accept;
  logic [3:0]  newStep, stepNext, stepPrev;

  logic [3:0]  step_q, step_d;
  logic        dir_q, dir_d;
  logic        edgePulse_q, edgePulse_d;
  logic [24:0] stepPeriod_q, stepPeriod_d;
  logic        periodValid_q, periodValid_d;
  logic [31:0] roundCNT_q, roundCNT_d;
  logic        hallErr_q, hallErr_d;
  logic        skipErr_q, skipErr_d;
  logic        stall_q, stall_d;
  logic [24:0] periodCnt_q, periodCnt_d;
  logic        roundInc, roundDec;

  function automatic logic [3:0] decode(input logic [2:0] code);
    case (code)
      3'b100:  decode = 4'd1;
      3'b110:  decode = 4'd2;
      3'b010:  decode = 4'd3;
      3'b011:  decode = 4'd4;
      3'b001:  decode = 4'd5;
      3'b101:  decode = 4'd6;
      default: decode = 4'd0;
    endcase
  endfunction

  // Two-flop synchroniser, candidate register and debounce counter. The
  // accepted code only moves once the candidate has been stable long enough.
  always_ff @(negedge clk or negedge nRst) begin
    if (!nRst) begin
      sync1_q   <= 3'b000;
      sync2_q   <= 3'b000;
      cand_q    <= 3'b000;
      acc_q     <= 3'b000;
      filtCnt_q <= 8'd0;
    end else begin
      sync1_q   <= {hallA, hallB, hallC};
      sync2_q   <= sync1_q;
      cand_q    <= sync2_q;
      filtCnt_q <= filtCnt_d;
      if (accept) acc_q <= cand_q;
    end
  end

  // Debounce counter restarts whenever the synchronised code disagrees with
  // the candidate and saturates once the candidate is considered stable.
  always_comb begin
    filtCnt_d = filtCnt_q;
    if (sync2_q != cand_q)
      filtCnt_d = 8'd0;
    else if (filtCnt_q != FILT_MAX)
      filtCnt_d = filtCnt_q + 8'd1;
  end

  // The step outputs update in the same cycle the accepted code loads, so
  // the decision is taken from the candidate rather than the accepted copy.
  assign accept   = (filtCnt_q == FILT_MAX) && (cand_q != acc_q);
  assign newStep  = decode(cand_q);
  assign stepNext = (step_q == 4'd6) ? 4'd1 : step_q + 4'd1;
  assign stepPrev = (step_q == 4'd1) ? 4'd6 : step_q - 4'd1;

  // Step tracking, period measurement, stall detection and revolution count.
  // An accepted change takes priority over the stall detect in the same cycle.
  // A skipped step still strobes edgePulse because it restarts the period
  // measurement; it just cannot produce a valid period.
  always_comb begin
    step_d        = step_q;
    dir_d         = dir_q;
    edgePulse_d   = 1'b0;
    hallErr_d     = 1'b0;
    skipErr_d     = 1'b0;
    stepPeriod_d  = stepPeriod_q;
    periodValid_d = periodValid_q;
    stall_d       = stall_q;
    roundInc      = 1'b0;
    roundDec      = 1'b0;
    periodCnt_d   = periodCnt_q;
    if (step_q != 4'd0 && periodCnt_q != STALL_LIMIT)
      periodCnt_d = periodCnt_q + 25'd1;

    if (accept) begin
      if (newStep == 4'd0) begin
        hallErr_d     = 1'b1;
        step_d        = 4'd0;
        periodValid_d = 1'b0;
      end else if (step_q == 4'd0) begin
        step_d      = newStep;
        edgePulse_d = 1'b1;
        periodCnt_d = 25'd1;
        stall_d     = 1'b0;
      end else if (newStep == stepNext || newStep == stepPrev) begin
        dir_d         = (newStep == stepNext);
        step_d        = newStep;
        edgePulse_d   = 1'b1;
        stepPeriod_d  = periodCnt_q;
        periodValid_d = 1'b1;
        periodCnt_d   = 25'd1;
        roundInc      = (newStep == stepNext) && (step_q == 4'd6);
        roundDec      = (newStep == stepPrev) && (step_q == 4'd1);
      end else begin
        skipErr_d     = 1'b1;
        step_d        = newStep;
        edgePulse_d   = 1'b1;
        periodValid_d = 1'b0;
        periodCnt_d   = 25'd1;
      end
    end else if (step_q != 4'd0 && periodCnt_q == STALL_LIMIT) begin
      stall_d       = 1'b1;
      step_d        = 4'd0;
      periodValid_d = 1'b0;
    end

    roundCNT_d = roundCNT_q;
    if (cntClr)
      roundCNT_d = 32'd0;
    else if (roundInc)
      roundCNT_d = roundCNT_q + 32'd1;
    else if (roundDec)
      roundCNT_d = roundCNT_q - 32'd1;
  end

  // Output and measurement registers.
  always_ff @(negedge clk or negedge nRst) begin
    if (!nRst) begin
      step_q        <= 4'd0;
      dir_q         <= 1'b1;
      edgePulse_q   <= 1'b0;
      stepPeriod_q  <= 25'd0;
      periodValid_q <= 1'b0;
      roundCNT_q    <= 32'd0;
      hallErr_q     <= 1'b0;
      skipErr_q     <= 1'b0;
      stall_q       <= 1'b0;
      periodCnt_q   <= 25'd0;
    end else begin
      step_q        <= step_d;
      dir_q         <= dir_d;
      edgePulse_q   <= edgePulse_d;
      stepPeriod_q  <= stepPeriod_d;
      periodValid_q <= periodValid_d;
      roundCNT_q    <= roundCNT_d;
      hallErr_q     <= hallErr_d;
      skipErr_q     <= skipErr_d;
      stall_q       <= stall_d;
      periodCnt_q   <= periodCnt_d;
    end
  end

  assign step        = step_q;
  assign dir         = dir_q;
  assign edgePulse   = edgePulse_q;
  assign stepPeriod  = stepPeriod_q;
  assign periodValid = periodValid_q;
  assign roundCNT    = roundCNT_q;
  assign hallErr     = hallErr_q;
  assign skipErr     = skipErr_q;
  assign stall       = stall_q;

endmodule

// File: tb/tb_motoro3_hall_decoder.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_motoro3_hall_decoder
//
// Drives Hall code sequences into motoro3_hall_decoder. Each driven code that
// should produce an event pushes its expected outputs and arrival cycle onto
// a queue; a monitor pops and compares whenever the decoder strobes
// edgePulse, hallErr or skipErr. Glitch, stall, counter-clear and reset
// behaviour are exercised by hand-written sequences.
// ---------------------------------------------------------------------------
module tb_motoro3_hall_decoder;

  localparam int          LATENCY     = 11;
  localparam logic [24:0] STALL_LIMIT = 25'd1000;
  localparam logic [31:0] MINUS1      = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        nRst = 1'b1;
  logic        hallA = 1'b0, hallB = 1'b0, hallC = 1'b0;
  logic        cntClr = 1'b0;
  logic [3:0]  step;
  logic        dir, edgePulse, periodValid, hallErr, skipErr, stall;
  logic [24:0] stepPeriod;
  logic [31:0] roundCNT;

  typedef struct {
    logic [2:0]  hall;
    int          hold;
    logic [3:0]  step;
    logic        dir;
    logic        edgeP;
    logic        hErr;
    logic        sErr;
    logic [24:0] period;
    logic        pv;
    logic [31:0] round;
  } vec_t;

  typedef struct {
    vec_t v;
    int   cyc;
  } exp_t;

  exp_t sbQ[$];
  exp_t monE;
  vec_t tbl[13];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   lastEdgeCyc = 0;
  int   waited;

  motoro3_hall_decoder #(
    .FILT_LEN(8),
    .STALL_LIMIT(STALL_LIMIT)
  ) dut (
    .clk(clk),
    .nRst(nRst),
    .hallA(hallA),
    .hallB(hallB),
    .hallC(hallC),
    .cntClr(cntClr),
    .step(step),
    .dir(dir),
    .edgePulse(edgePulse),
    .stepPeriod(stepPeriod),
    .periodValid(periodValid),
    .roundCNT(roundCNT),
    .hallErr(hallErr),
    .skipErr(skipErr),
    .stall(stall)
  );

  // 10 MHz clock; the design works on the falling edge.
  always #50 clk = ~clk;

  // Count falling edges so expected arrival cycles can be computed.
  always @(negedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  function automatic vec_t mkVec(input logic [2:0] hall, input int hold, input logic [3:0] st,
                                 input logic d, input logic ep, input logic he, input logic se,
                                 input logic [24:0] per, input logic pv, input logic [31:0] rnd);
    vec_t v;
    v.hall = hall; v.hold = hold; v.step = st; v.dir = d; v.edgeP = ep;
    v.hErr = he; v.sErr = se; v.period = per; v.pv = pv; v.round = rnd;
    return v;
  endfunction

  // Drive a code, queue the event it must produce, then hold it.
  task automatic applyStimulus(input vec_t v);
    exp_t e;
    {hallA, hallB, hallC} = v.hall;
    e.v   = v;
    e.cyc = cyc + LATENCY;
    sbQ.push_back(e);
    repeat (v.hold) @(posedge clk);
  endtask

  task automatic checkResetState();
    checkOutput("rst step", 32'(step), 32'd0);
    checkOutput("rst dir", 32'(dir), 32'd1);
    checkOutput("rst edgePulse", 32'(edgePulse), 32'd0);
    checkOutput("rst stepPeriod", 32'(stepPeriod), 32'd0);
    checkOutput("rst periodValid", 32'(periodValid), 32'd0);
    checkOutput("rst roundCNT", roundCNT, 32'd0);
    checkOutput("rst hallErr", 32'(hallErr), 32'd0);
    checkOutput("rst skipErr", 32'(skipErr), 32'd0);
    checkOutput("rst stall", 32'(stall), 32'd0);
  endtask

  // Scoreboard monitor: every strobe must match the oldest queued event.
  always @(posedge clk) begin
    if (nRst && (edgePulse || hallErr || skipErr)) begin
      if (edgePulse) lastEdgeCyc = cyc;
      total++;
      if (sbQ.size() == 0) begin
        bad++;
        $display("[TB] FAIL unexpected event at cycle %0d: got step=%0d edge=%0b hallErr=%0b skipErr=%0b expected none",
                 cyc, step, edgePulse, hallErr, skipErr);
      end else begin
        monE = sbQ.pop_front();
        checkOutput("event cycle", 32'(cyc), 32'(monE.cyc));
        checkOutput("step", 32'(step), 32'(monE.v.step));
        checkOutput("dir", 32'(dir), 32'(monE.v.dir));
        checkOutput("edgePulse", 32'(edgePulse), 32'(monE.v.edgeP));
        checkOutput("hallErr", 32'(hallErr), 32'(monE.v.hErr));
        checkOutput("skipErr", 32'(skipErr), 32'(monE.v.sErr));
        checkOutput("stepPeriod", 32'(stepPeriod), 32'(monE.v.period));
        checkOutput("periodValid", 32'(periodValid), 32'(monE.v.pv));
        checkOutput("roundCNT", roundCNT, monE.v.round);
        checkOutput("event stall", 32'(stall), 32'd0);
      end
    end
  end

  // Hard time limit so the run always ends.
  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: run exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    // Reverse rotation at 300 cycles/step, then forward at 500 cycles/step.
    tbl[0]  = mkVec(3'b100, 300, 4'd1, 1'b1, 1'b1, 1'b0, 1'b0, 25'd0,   1'b0, 32'd0);
    tbl[1]  = mkVec(3'b101, 300, 4'd6, 1'b0, 1'b1, 1'b0, 1'b0, 25'd300, 1'b1, MINUS1);
    tbl[2]  = mkVec(3'b001, 300, 4'd5, 1'b0, 1'b1, 1'b0, 1'b0, 25'd300, 1'b1, MINUS1);
    tbl[3]  = mkVec(3'b011, 300, 4'd4, 1'b0, 1'b1, 1'b0, 1'b0, 25'd300, 1'b1, MINUS1);
    tbl[4]  = mkVec(3'b010, 300, 4'd3, 1'b0, 1'b1, 1'b0, 1'b0, 25'd300, 1'b1, MINUS1);
    tbl[5]  = mkVec(3'b110, 300, 4'd2, 1'b0, 1'b1, 1'b0, 1'b0, 25'd300, 1'b1, MINUS1);
    tbl[6]  = mkVec(3'b100, 500, 4'd1, 1'b0, 1'b1, 1'b0, 1'b0, 25'd300, 1'b1, MINUS1);
    tbl[7]  = mkVec(3'b110, 500, 4'd2, 1'b1, 1'b1, 1'b0, 1'b0, 25'd500, 1'b1, MINUS1);
    tbl[8]  = mkVec(3'b010, 500, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0, 25'd500, 1'b1, MINUS1);
    tbl[9]  = mkVec(3'b011, 500, 4'd4, 1'b1, 1'b1, 1'b0, 1'b0, 25'd500, 1'b1, MINUS1);
    tbl[10] = mkVec(3'b001, 500, 4'd5, 1'b1, 1'b1, 1'b0, 1'b0, 25'd500, 1'b1, MINUS1);
    tbl[11] = mkVec(3'b101, 500, 4'd6, 1'b1, 1'b1, 1'b0, 1'b0, 25'd500, 1'b1, MINUS1);
    tbl[12] = mkVec(3'b100, 500, 4'd1, 1'b1, 1'b1, 1'b0, 1'b0, 25'd500, 1'b1, 32'd0);

    #10 nRst = 1'b0;
    repeat (3) @(posedge clk);
    checkResetState();
    nRst = 1'b1;

    for (int i = 0; i < 13; i++) applyStimulus(tbl[i]);

    // Short glitch must be filtered out completely.
    {hallA, hallB, hallC} = 3'b110;
    repeat (5) @(posedge clk);
    {hallA, hallB, hallC} = 3'b100;
    repeat (30) @(posedge clk);
    checkOutput("glitch step", 32'(step), 32'd1);

    // Illegal code, then recovery with no period.
    applyStimulus(mkVec(3'b111, 20,  4'd0, 1'b1, 1'b0, 1'b1, 1'b0, 25'd500, 1'b0, 32'd0));
    checkOutput("illegal step", 32'(step), 32'd0);
    applyStimulus(mkVec(3'b100, 200, 4'd1, 1'b1, 1'b1, 1'b0, 1'b0, 25'd500, 1'b0, 32'd0));

    // Step 2 held until the stall detect fires.
    applyStimulus(mkVec(3'b110, 0,   4'd2, 1'b1, 1'b1, 1'b0, 1'b0, 25'd200, 1'b1, 32'd0));
    waited = 0;
    while (!stall && waited < 1100) begin
      @(posedge clk);
      waited++;
    end
    checkOutput("stall seen", 32'(stall), 32'd1);
    checkOutput("stall delay", 32'(cyc - lastEdgeCyc), 32'd1000);
    checkOutput("stall step", 32'(step), 32'd0);
    checkOutput("stall periodValid", 32'(periodValid), 32'd0);
    checkOutput("stall stepPeriod", 32'(stepPeriod), 32'd200);

    // Recovery from stall, then a skipped step and a clean forward step.
    applyStimulus(mkVec(3'b010, 100, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0, 25'd200, 1'b0, 32'd0));
    checkOutput("stall cleared", 32'(stall), 32'd0);
    applyStimulus(mkVec(3'b001, 150, 4'd5, 1'b1, 1'b1, 1'b0, 1'b1, 25'd200, 1'b0, 32'd0));
    applyStimulus(mkVec(3'b101, 120, 4'd6, 1'b1, 1'b1, 1'b0, 1'b0, 25'd150, 1'b1, 32'd0));

    // 6->1 edge coinciding with cntClr: the clear wins.
    applyStimulus(mkVec(3'b100, 0,   4'd1, 1'b1, 1'b1, 1'b0, 1'b0, 25'd120, 1'b1, 32'd0));
    repeat (LATENCY - 1) @(posedge clk);
    cntClr = 1'b1;
    @(posedge clk);
    cntClr = 1'b0;
    repeat (89) @(posedge clk);

    // 1->6 reverse so several outputs are non-default before reset.
    applyStimulus(mkVec(3'b101, 50,  4'd6, 1'b0, 1'b1, 1'b0, 1'b0, 25'd100, 1'b1, MINUS1));
    nRst = 1'b0;
    #1;
    checkResetState();
    repeat (3) @(posedge clk);
    nRst = 1'b1;
    applyStimulus(mkVec(3'b101, 40,  4'd6, 1'b1, 1'b1, 1'b0, 1'b0, 25'd0,   1'b0, 32'd0));

    checkOutput("scoreboard drained", 32'(sbQ.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/motoro3_hall_decoder.md
# motoro3_hall_decoder

Receive side of the three-phase commutation path. Samples the three Hall-effect rotor position sensors and filters them, then decodes the step number 1..6 using the same numbering as the commutation step counter. Reports rotation direction, measured step period, revolution count, and error/stall status. Sits between the motor's Hall inputs and the speed/closed-loop logic; all flops run on the falling edge of the 10 MHz clk.

## Interface
- FILT_LEN, 8: consecutive identical synchronized samples required before a Hall code is accepted (2..255).
- STALL_LIMIT, 25'd1_666_667: step-period count at which the rotor is declared stalled (~166.7 ms).
- clk  input  1  10 MHz system clock; all state updates on negedge.
- nRst  input  1  reset, asynchronous, active-low.
- hallA, hallB, hallC  input  1 each  asynchronous Hall sensor levels.
- cntClr  input  1  synchronous clear of roundCNT.
- step  output  4  decoded step: 0 = invalid/unknown, 1..6 = rotor sector.
- dir  output  1  1 = forward (ascending steps), 0 = reverse.
- edgePulse  output  1  one-cycle strobe on each accepted valid step change.
- stepPeriod  output  25  clk cycles between the last two consecutive edgePulses.
- periodValid  output  1  stepPeriod holds a measurement from two adjacent-step edges.
- roundCNT  output  32  signed revolution count: +1 per 6->1, -1 per 1->6, two's-complement wrap.
- hallErr  output  1  one-cycle pulse when an illegal code (000/111) is accepted.
- skipErr  output  1  one-cycle pulse when a non-adjacent step change is accepted.
- stall  output  1  level; no accepted edge within STALL_LIMIT cycles.

## Operation
- Code {hallA,hallB,hallC} to step: 100->1, 110->2, 010->3, 011->4, 001->5, 101->6; 000/111 -> 0.
- Sync: 2 flops per input, reset 0.
- Filter: the candidate register loads sync output. The counter resets to 0 when the sync output differs from the candidate, and increments otherwise, saturating at FILT_LEN-1. The accepted code loads the candidate when the counter equals FILT_LEN-1 and the candidate differs from the accepted code. The accepted code resets to 000, with no hallErr on reset.
- On an accepted change, with newStep = decode(accepted), prev = step:
  - newStep==0: hallErr=1, step<=0, periodValid<=0, dir unchanged.
  - prev==0 (after reset, error, or stall): step<=newStep, edgePulse=1, periodCnt<=1, periodValid unchanged (0), stall<=0.
  - newStep==prev+1 (6->1 wraps): dir<=1, edgePulse=1, stepPeriod<=periodCnt, periodValid<=1, periodCnt<=1; roundCNT+1 if 6->1.
  - newStep==prev-1 (1->6 wraps): dir<=0, same period update; roundCNT-1 if 1->6.
  - otherwise: skipErr=1, step<=newStep, edgePulse=1, periodValid<=0, periodCnt<=1, dir unchanged.
- periodCnt increments each cycle while step!=0 and saturates at STALL_LIMIT. When it reaches STALL_LIMIT: stall<=1, step<=0, periodValid<=0. stepPeriod holds its last value.
- Precedence within one cycle:
  - An accepted change beats the stall detect.
  - cntClr beats the roundCNT inc/dec.
- Reset values: step 0, dir 1, edgePulse 0, stepPeriod 0, periodValid 0, roundCNT 0, hallErr 0, skipErr 0, stall 0, periodCnt 0, filter state 0.
- nRst asserted mid-rotation clears everything immediately. The first accepted code after release is treated as prev==0, so it produces no period and no roundCNT change.

## Timing
- Latency: a Hall level change first sampled at negedge N, then held stable, appears on step/edgePulse/errors at negedge N+FILT_LEN+2. This is 10 clk for the default.
- Glitches held for fewer than FILT_LEN sync samples produce no output change.
- Pulse outputs are high for exactly one clk.
- edgePulse, hallErr and skipErr are mutually exclusive.
- stepPeriod = K when consecutive edgePulses are K cycles apart.

## Test plan
- Reset, then hold 100: step=1 at the 10th negedge. edgePulse pulses once. periodValid=0, roundCNT=0, hallErr stays 0.
- Forward sequence 100,110,010,011,001,101,100 with 500 clk per step (FILT_LEN=8):
  - dir=1; stepPeriod=500 and periodValid=1 from the 2nd edge on.
  - roundCNT=1 after 101->100.
- Reverse sequence from step 1 to 101 and on down, 300 clk per step: dir=0, stepPeriod=300, roundCNT=-1 (0xFFFFFFFF) after 1->6.
- Glitches and illegal codes:
  - A 5-cycle glitch 100->110->100 produces no change.
  - Holding 111 for 20 cycles gives hallErr for one cycle and step=0.
  - Returning to 100 gives step=1 with periodValid=0.
- With STALL_LIMIT=1000 and step 2 held:
  - stall=1 and step=0 exactly 1000 cycles after the last edgePulse.
  - The next code 010 clears stall with no period.
  - A jump 010->001 gives skipErr and periodValid=0.
- cntClr asserted in the same cycle as a 6->1 edge: roundCNT=0. Asserting nRst mid-rotation returns all outputs to their reset values.
